// File: rtl/lagarto_l15_req_arbiter.sv
// lagarto_l15_req_arbiter: shares the tile L1.5 request channel between fetch (0) and dcache (1)
// Build option LAGARTO_L15_ARB_FIXED_PRIO_EN: dcache always wins ties instead of round-robin.
module lagarto_l15_req_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_val_i,
    input  logic [9:0]            req_rqtype_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [127:0]          req_data_i,
    input  logic [5:0]            req_size_i,
    input  logic [1:0]            req_nc_i,
    output logic [1:0]            req_ack_o,
    output logic                  l15_val_o,
    output logic [4:0]            l15_rqtype_o,
    output logic [ADDR_W-1:0]     l15_addr_o,
    output logic [63:0]           l15_data_o,
    output logic [2:0]            l15_size_o,
    output logic                  l15_nc_o,
    output logic                  l15_tag_o,
    input  logic                  l15_ack_i,
    input  logic                  l15_rtrn_val_i,
    input  logic                  l15_rtrn_tag_i,
    output logic [1:0]            rtrn_val_o,
    output logic                  l15_rtrn_ack_o,
    output logic                  err_o
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    logic              state_q, state_d;
    logic              prio_q, prio_d;
    logic              err_q, err_d;
    logic              tag_q, tag_d;
    logic [4:0]        rqtype_q, rqtype_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [2:0]        size_q, size_d;
    logic              nc_q, nc_d;
    logic [CW-1:0]     cnt_q [2];
    logic [CW-1:0]     cnt_d [2];
    logic [1:0]        elig;
    logic              gnt, grant, ack;

    assign ack            = (state_q == HOLD) & l15_ack_i;
    assign req_ack_o      = {ack & tag_q, ack & ~tag_q};
    assign rtrn_val_o     = {l15_rtrn_val_i & l15_rtrn_tag_i, l15_rtrn_val_i & ~l15_rtrn_tag_i};
    assign l15_rtrn_ack_o = l15_rtrn_val_i;
    assign l15_val_o      = (state_q == HOLD);
    assign l15_tag_o      = tag_q;
    assign l15_rqtype_o   = rqtype_q;
    assign l15_addr_o     = addr_q;
    assign l15_data_o     = data_q;
    assign l15_size_o     = size_q;
    assign l15_nc_o       = nc_q;
    assign err_o          = err_q;

    // pick a requester in IDLE, latch its fields, and track outstanding counts per requester
    always_comb begin
        elig[0] = req_val_i[0] & (cnt_q[0] < MAX_C);
        elig[1] = req_val_i[1] & (cnt_q[1] < MAX_C);
`ifdef LAGARTO_L15_ARB_FIXED_PRIO_EN
        gnt = elig[1];
`else
        gnt = (&elig) ? prio_q : elig[1];
`endif
        grant    = (state_q == IDLE) & (|elig);
        state_d  = grant ? HOLD : ack ? IDLE : state_q;
        prio_d   = ack ? ~tag_q : prio_q;
        tag_d    = grant ? gnt : tag_q;
        rqtype_d = grant ? (gnt ? req_rqtype_i[9:5] : req_rqtype_i[4:0]) : rqtype_q;
        addr_d   = grant ? (gnt ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0]) : addr_q;
        data_d   = grant ? (gnt ? req_data_i[127:64] : req_data_i[63:0]) : data_q;
        size_d   = grant ? (gnt ? req_size_i[5:3] : req_size_i[2:0]) : size_q;
        nc_d     = grant ? (gnt ? req_nc_i[1] : req_nc_i[0]) : nc_q;
        err_d    = err_q | (rtrn_val_o[0] & (cnt_q[0] == '0)) | (rtrn_val_o[1] & (cnt_q[1] == '0));
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = (req_ack_o[i] & ~rtrn_val_o[i]) ? cnt_q[i] + ONE_C :
                       (rtrn_val_o[i] & ~req_ack_o[i] & (cnt_q[i] != '0)) ? cnt_q[i] - ONE_C : cnt_q[i];
        end
    end

    // state registers; reset drops any held request and clears all counts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            err_q    <= 1'b0;
            tag_q    <= 1'b0;
            rqtype_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
            nc_q     <= 1'b0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
            rqtype_q <= rqtype_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
            nc_q     <= nc_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end
endmodule

// File: tb/tb_lagarto_l15_req_arbiter.sv
// tb_lagarto_l15_req_arbiter: directed and random checks against a transaction-level model
module tb_lagarto_l15_req_arbiter;
    localparam int MAX_OUT = 4;
    localparam int AW      = 40;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [1:0]      req_val_i = '0;
    logic [9:0]      req_rqtype_i = '0;
    logic [2*AW-1:0] req_addr_i = '0;
    logic [127:0]    req_data_i = '0;
    logic [5:0]      req_size_i = '0;
    logic [1:0]      req_nc_i = '0;
    logic [1:0]      req_ack_o;
    logic            l15_val_o;
    logic [4:0]      l15_rqtype_o;
    logic [AW-1:0]   l15_addr_o;
    logic [63:0]     l15_data_o;
    logic [2:0]      l15_size_o;
    logic            l15_nc_o;
    logic            l15_tag_o;
    logic            l15_ack_i = 1'b0;
    logic            l15_rtrn_val_i = 1'b0;
    logic            l15_rtrn_tag_i = 1'b0;
    logic [1:0]      rtrn_val_o;
    logic            l15_rtrn_ack_o;
    logic            err_o;

    int nchk = 0;
    int nerr = 0;

    // model: one in-flight presented transaction plus per-requester outstanding counts
    bit            m_val, m_tag, m_prio, m_err, m_nc;
    logic [4:0]    m_rq;
    logic [AW-1:0] m_addr;
    logic [63:0]   m_data;
    logic [2:0]    m_sz;
    int            m_cnt [2];

    lagarto_l15_req_arbiter #(.MAX_OUT(MAX_OUT), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_size_i(req_size_i),
        .req_nc_i(req_nc_i), .req_ack_o(req_ack_o), .l15_val_o(l15_val_o),
        .l15_rqtype_o(l15_rqtype_o), .l15_addr_o(l15_addr_o), .l15_data_o(l15_data_o),
        .l15_size_o(l15_size_o), .l15_nc_o(l15_nc_o), .l15_tag_o(l15_tag_o),
        .l15_ack_i(l15_ack_i), .l15_rtrn_val_i(l15_rtrn_val_i), .l15_rtrn_tag_i(l15_rtrn_tag_i),
        .rtrn_val_o(rtrn_val_o), .l15_rtrn_ack_o(l15_rtrn_ack_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        nchk++;
        if (o !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", t, o, e);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_tag = 0; m_prio = 0; m_err = 0; m_nc = 0;
        m_rq = '0; m_addr = '0; m_data = '0; m_sz = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic check_outs();
        chk("l15_val", 64'(l15_val_o), 64'(m_val));
        chk("l15_tag", 64'(l15_tag_o), 64'(m_tag));
        chk("l15_rqtype", 64'(l15_rqtype_o), 64'(m_rq));
        chk("l15_addr", 64'(l15_addr_o), 64'(m_addr));
        chk("l15_data", l15_data_o, m_data);
        chk("l15_size", 64'(l15_size_o), 64'(m_sz));
        chk("l15_nc", 64'(l15_nc_o), 64'(m_nc));
        chk("req_ack", 64'(req_ack_o), (m_val && l15_ack_i) ? 64'(1) << m_tag : 64'(0));
        chk("rtrn_val", 64'(rtrn_val_o), l15_rtrn_val_i ? 64'(1) << l15_rtrn_tag_i : 64'(0));
        chk("rtrn_ack", 64'(l15_rtrn_ack_o), 64'(l15_rtrn_val_i));
        chk("err", 64'(err_o), 64'(m_err));
        chk("cnt0", 64'(dut.cnt_q[0]), 64'(m_cnt[0]));
        chk("cnt1", 64'(dut.cnt_q[1]), 64'(m_cnt[1]));
    endtask

    task automatic model_step();
        bit acked, ack_tag, e0, e1, inc, dec;
        int g;
        if (rst_i) begin
            model_reset();
            return;
        end
        acked   = m_val && l15_ack_i;
        ack_tag = m_tag;
        if (m_val) begin
            if (l15_ack_i) begin
                m_val  = 0;
                m_prio = !m_tag;
            end
        end else begin
            e0 = req_val_i[0] && m_cnt[0] < MAX_OUT;
            e1 = req_val_i[1] && m_cnt[1] < MAX_OUT;
            if (e0 || e1) begin
`ifdef LAGARTO_L15_ARB_FIXED_PRIO_EN
                g = (e0 && e1) ? 1 : int'(e1);
`else
                g = (e0 && e1) ? int'(m_prio) : int'(e1);
`endif
                m_val  = 1;
                m_tag  = g[0];
                m_rq   = req_rqtype_i[g*5 +: 5];
                m_addr = req_addr_i[g*AW +: AW];
                m_data = req_data_i[g*64 +: 64];
                m_sz   = req_size_i[g*3 +: 3];
                m_nc   = req_nc_i[g];
            end
        end
        for (int i = 0; i < 2; i++) begin
            inc = acked && int'(ack_tag) == i;
            dec = l15_rtrn_val_i && int'(l15_rtrn_tag_i) == i;
            if (dec && m_cnt[i] == 0) m_err = 1;
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] v, input logic a, input logic rv, input logic rt);
        @(negedge clk_i);
        rst_i = r;
        req_val_i = v;
        l15_ack_i = a;
        l15_rtrn_val_i = rv;
        l15_rtrn_tag_i = rt;
        for (int i = 0; i < 2; i++) begin
            req_rqtype_i[i*5 +: 5]  = 5'($urandom);
            req_addr_i[i*AW +: AW]  = AW'({$urandom, $urandom});
            req_data_i[i*64 +: 64]  = {$urandom, $urandom};
            req_size_i[i*3 +: 3]    = 3'($urandom);
            req_nc_i[i]             = 1'($urandom);
        end
        #1;
        check_outs();
        model_step();
    endtask

    task automatic do_reset();
        cyc(1, 2'b00, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
    endtask

    initial begin
        int t;
        logic rv;
        model_reset();
        do_reset();
        cyc(0, 2'b00, 0, 0, 0);
        // single requester, ack on the fourth cycle
        cyc(0, 2'b01, 0, 0, 0);
        cyc(0, 2'b01, 0, 0, 0);
        chk("single_val", 64'(l15_val_o), 64'(1));
        cyc(0, 2'b01, 0, 0, 0);
        cyc(0, 2'b01, 1, 0, 0);
        chk("single_ack", 64'(req_ack_o), 64'(1));
        cyc(0, 2'b00, 0, 0, 0);
        chk("single_cnt0", 64'(dut.cnt_q[0]), 64'(1));
        // round-robin with immediate acks from prio 0
        do_reset();
        for (int i = 0; i < 12; i++) cyc(0, 2'b11, 1, 0, 0);
        // throttle requester 0 at MAX_OUT
        do_reset();
        for (int i = 0; i < MAX_OUT; i++) begin
            cyc(0, 2'b01, 0, 0, 0);
            cyc(0, 2'b01, 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 2'b01, 0, 0, 0);
        chk("thr_blocked", 64'(l15_val_o), 64'(0));
        chk("thr_cnt0", 64'(dut.cnt_q[0]), 64'(MAX_OUT));
        cyc(0, 2'b01, 0, 1, 0);
        cyc(0, 2'b01, 0, 0, 0);
        cyc(0, 2'b01, 0, 0, 0);
        chk("thr_release", 64'(l15_val_o), 64'(1));
        cyc(0, 2'b01, 1, 0, 0);
        // simultaneous ack and return for requester 1
        do_reset();
        cyc(0, 2'b10, 0, 0, 0);
        cyc(0, 2'b10, 1, 0, 0);
        cyc(0, 2'b10, 0, 0, 0);
        cyc(0, 2'b10, 1, 1, 1);
        chk("sim_rtrn", 64'(rtrn_val_o), 64'(2));
        cyc(0, 2'b00, 0, 0, 0);
        chk("sim_cnt1", 64'(dut.cnt_q[1]), 64'(1));
        // randomized traffic with legal returns
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            t  = int'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) == 0) && m_cnt[t] > 0;
            cyc(0, 2'($urandom), 1'($urandom_range(0, 2) == 0), rv, t[0]);
        end
        // reset while holding a request
        do_reset();
        cyc(0, 2'b01, 0, 0, 0);
        cyc(1, 2'b01, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0);
        chk("rst_hold_val", 64'(l15_val_o), 64'(0));
        // underflow is sticky until reset
        cyc(0, 2'b00, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 2'b00, 0, 0, 0);
        chk("err_sticky", 64'(err_o), 64'(1));
        do_reset();
        cyc(0, 2'b00, 0, 0, 0);
        chk("err_clear", 64'(err_o), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
